regbank_p4_arbiter: RTL and testbench
=====================================

Name: regbank_p4_arbiter

Overview:
- Shares the single instruction port of the RegBankP4 4-register bank (12-bit inst = 4-bit opcode + 8-bit immediate, plus inst_en) between N_REQ independent requesters.
- Round-robin arbitration with a valid/ready handshake per requester and a registered output stage driving RegBankP4 inst/inst_en directly.
- Illegal opcodes are consumed but never forwarded; the first one is captured in a sticky error register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of the error source index; must equal clog2(N_REQ).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_inst  in  12*N_REQ  packed requester instructions; requester i occupies bits [12*i+11:12*i].
- req_valid  in  N_REQ  requester i has an instruction pending.
- req_ready  out  N_REQ  combinational; requester i's instruction is consumed this cycle.
- halt  in  1  when high, no grants are issued.
- err_clr  in  1  clears the sticky error.
- inst  out  12  instruction to RegBankP4.
- inst_en  out  1  inst is valid this cycle.
- grant  out  N_REQ  one-hot source of the instruction currently on inst/inst_en; all zero when inst_en=0.
- err  out  1  sticky illegal-opcode flag.
- err_src  out  SRC_W  requester index of the first captured illegal instruction.
- err_op  out  4  opcode of the first captured illegal instruction.

Behaviour:
- Legal opcodes are the RegBankP4 set: NOP, LD0, LD1, LD2, LD3 (the RegBankP4 opcode defines). Every other value, e.g. 4'hF, is illegal.
- Round-robin pointer ptr (SRC_W bits), reset value 0.
- Winner selection: first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
- req_ready[winner]=1 when halt=0 and reset=0; all other req_ready bits are 0. At most one bit of req_ready is high.
- req_ready is combinational from req_valid, ptr and halt. Requesters must hold req_inst stable while valid is high and ready is low.
- Accept occurs on a cycle with req_valid[i] & req_ready[i].
  - On accept, ptr <= (i+1) mod N_REQ. ptr is unchanged on cycles with no accept.
- Legal accept, effective at the next clock edge (latency 1):
  - inst <= req_inst[i]
  - inst_en <= 1
  - grant <= one-hot(i)
  - NOP is legal and is forwarded.
- Illegal accept: inst_en <= 0, grant <= 0, and inst holds its value.
  - If err=0: err <= 1, err_src <= i, err_op <= opcode.
  - If err=1: err_src and err_op are unchanged (first-error capture).
- No accept: inst_en <= 0, grant <= 0, inst holds its previous value.
- err_clr: err <= 0 at the next edge. If an illegal accept occurs in the same cycle, the new error wins: err stays 1 and err_src/err_op take the new values.
- Fairness: a requester with req_valid held high is accepted within N_REQ accepts.
- Throughput: up to one accept per cycle; back-to-back grants to different requesters are allowed.
- halt=1: no accept occurs, inst_en <= 0, ptr holds, the error register is unaffected, and err_clr is still honoured.
- Reset (asynchronous, active-high):
  - Immediately: inst=12'h000, inst_en=0, grant=0, err=0, err_src=0, err_op=0, ptr=0.
  - req_ready is forced to 0 while reset is high; nothing is accepted.
  - Reset mid-stream drops any in-flight output. The first accept after release scans from requester 0.

Test Plan:
- Only req_valid[2] high with {LD1,8'hFE} -> req_ready=4'b0100 in the same cycle; next edge inst={LD1,8'hFE}, inst_en=1, grant=4'b0100; the following cycle inst_en=0.
- All four requesters continuously valid with {LD0,8'hBA}, {LD1,8'h87}, {LD2,8'h23}, {LD3,8'h43} -> issue order 0,1,2,3,0,1 on consecutive cycles; each req_ready is high exactly once per 4 cycles.
- Requester 1 sends {4'hF,8'hAB}, then requester 3 sends {4'hE,8'h00} -> neither is forwarded (inst_en=0); err=1, err_src=1, err_op=4'hF after both; assert err_clr -> err=0.
- err_clr asserted in the same cycle requester 0 sends {4'hF,8'h11} -> err stays 1, err_src=0, err_op=4'hF.
- halt=1 for 4 cycles with req_valid=4'b1111 and ptr=2 -> req_ready=0 and inst_en=0 throughout; after halt drops, the first grant goes to requester 2.
- reset pulsed mid-stream while inst_en=1 from requester 3 -> inst=0, inst_en=0, grant=0 immediately; after release with req_valid=4'b1010 the first grant goes to requester 1.

Source files
------------

// File: rtl/regbank_p4_arbiter.sv
// Round-robin arbiter sharing the RegBankP4 instruction port among N_REQ requesters.
// Latency 1 (registered inst/inst_en/grant); req_ready is combinational, one winner per cycle, none while halt/reset.
module regbank_p4_arbiter #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [12*N_REQ-1:0]   req_inst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  halt,
  input  logic                  err_clr,
  output logic [11:0]           inst,
  output logic                  inst_en,
  output logic [N_REQ-1:0]      grant,
  output logic                  err,
  output logic [SRC_W-1:0]      err_src,
  output logic [3:0]            err_op
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD0 = 4'h1;
  localparam logic [3:0] OP_LD1 = 4'h2;
  localparam logic [3:0] OP_LD2 = 4'h3;
  localparam logic [3:0] OP_LD3 = 4'h4;

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [11:0]      inst_q, inst_d;
  logic             inst_en_q, inst_en_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             err_q, err_d;
  logic [SRC_W-1:0] err_src_q, err_src_d;
  logic [3:0]       err_op_q, err_op_d;

  logic             win_found;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] win_nxt;
  logic [11:0]      win_inst;
  logic             win_legal;
  logic             accept;

  function automatic int wrap(input int v);
    return v % N_REQ;
  endfunction

  // Scan from the far end back to ptr so the nearest valid requester is the last one kept.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_nxt   = '0;
    win_inst  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap(int'(ptr_q) + k)]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(wrap(int'(ptr_q) + k));
        win_nxt   = SRC_W'(wrap(int'(ptr_q) + k + 1));
        win_inst  = req_inst[12*wrap(int'(ptr_q) + k) +: 12];
      end
    end
  end

  always_comb begin
    case (win_inst[11:8])
      OP_NOP, OP_LD0, OP_LD1, OP_LD2, OP_LD3: win_legal = 1'b1;
      default:                                win_legal = 1'b0;
    endcase
  end

  assign accept = win_found & ~halt & ~reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    inst_d    = inst_q;
    inst_en_d = 1'b0;
    grant_d   = '0;
    err_d     = err_q;
    err_src_d = err_src_q;
    err_op_d  = err_op_q;

    if (err_clr) err_d = 1'b0;

    if (accept) begin
      ptr_d = win_nxt;
      if (win_legal) begin
        inst_d            = win_inst;
        inst_en_d         = 1'b1;
        grant_d[win_idx]  = 1'b1;
      end else if (!err_q || err_clr) begin
        // A fresh illegal opcode outranks a simultaneous clear.
        err_d     = 1'b1;
        err_src_d = win_idx;
        err_op_d  = win_inst[11:8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      inst_q    <= 12'h000;
      inst_en_q <= 1'b0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      err_src_q <= '0;
      err_op_q  <= 4'h0;
    end else begin
      ptr_q     <= ptr_d;
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
      err_op_q  <= err_op_d;
    end
  end

  assign inst    = inst_q;
  assign inst_en = inst_en_q;
  assign grant   = grant_q;
  assign err     = err_q;
  assign err_src = err_src_q;
  assign err_op  = err_op_q;

endmodule

// File: tb/tb_regbank_p4_arbiter.sv
// Vector-table bench for regbank_p4_arbiter with a queue of expected registered outputs.
module tb_regbank_p4_arbiter;

  logic        clock;
  logic        reset;
  logic [47:0] req_inst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic        halt;
  logic        err_clr;
  logic [11:0] inst;
  logic        inst_en;
  logic [3:0]  grant;
  logic        err;
  logic [1:0]  err_src;
  logic [3:0]  err_op;

  int total = 0;
  int bad   = 0;

  regbank_p4_arbiter #(.N_REQ(4), .SRC_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_inst  (req_inst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .halt      (halt),
    .err_clr   (err_clr),
    .inst      (inst),
    .inst_en   (inst_en),
    .grant     (grant),
    .err       (err),
    .err_src   (err_src),
    .err_op    (err_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] i_inst;
    logic [3:0]  i_vld;
    logic        i_halt;
    logic        i_clr;
    logic [3:0]  e_rdy;
    logic [11:0] e_inst;
    logic        e_en;
    logic [3:0]  e_gnt;
    logic        e_err;
    logic [1:0]  e_src;
    logic [3:0]  e_op;
  } vec_t;

  typedef struct {
    int          id;
    logic [11:0] e_inst;
    logic        e_en;
    logic [3:0]  e_gnt;
    logic        e_err;
    logic [1:0]  e_src;
    logic [3:0]  e_op;
  } exp_t;

  vec_t vt[40];
  int   nv = 0;
  exp_t sb[$];

  localparam logic [47:0] STD = {12'h443, 12'h323, 12'h287, 12'h1BA};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic add(input logic [47:0] ii, input logic [3:0] vld, input logic hlt, input logic clr,
                     input logic [3:0] rdy, input logic [11:0] oi, input logic oen, input logic [3:0] og,
                     input logic oe, input logic [1:0] os, input logic [3:0] oo);
    vt[nv] = '{ii, vld, hlt, clr, rdy, oi, oen, og, oe, os, oo};
    nv++;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk($sformatf("%s inst", tag),    {4'h0, inst},        {4'h0, e.e_inst});
    chk($sformatf("%s inst_en", tag), {15'h0, inst_en},    {15'h0, e.e_en});
    chk($sformatf("%s grant", tag),   {12'h0, grant},      {12'h0, e.e_gnt});
    chk($sformatf("%s err", tag),     {15'h0, err},        {15'h0, e.e_err});
    chk($sformatf("%s err_src", tag), {14'h0, err_src},    {14'h0, e.e_src});
    chk($sformatf("%s err_op", tag),  {12'h0, err_op},     {12'h0, e.e_op});
  endtask

  task automatic apply(input int n);
    exp_t e;
    @(negedge clock);
    req_inst  = vt[n].i_inst;
    req_valid = vt[n].i_vld;
    halt      = vt[n].i_halt;
    err_clr   = vt[n].i_clr;
    #1;
    chk($sformatf("v%0d req_ready", n), {12'h0, req_ready}, {12'h0, vt[n].e_rdy});
    sb.push_back('{n, vt[n].e_inst, vt[n].e_en, vt[n].e_gnt, vt[n].e_err, vt[n].e_src, vt[n].e_op});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      bad++;
      total++;
      $display("FAIL v%0d scoreboard empty", n);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("v%0d", e.id), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset = 1'b1; req_inst = '0; req_valid = '0; halt = 1'b0; err_clr = 1'b0;
    #1;
    e = '{-1, 12'h000, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
    check_outputs("reset", e);
    chk("reset req_ready", {12'h0, req_ready}, 16'h0);

    // single requester 2 with {LD1,FE}, then idle
    add({12'h443, 12'h2FE, 12'h287, 12'h1BA}, 4'b0100, 0, 0, 4'b0100, 12'h2FE, 1, 4'b0100, 0, 2'd0, 4'h0);
    add(STD, 4'b0000, 0, 0, 4'b0000, 12'h2FE, 0, 4'b0000, 0, 2'd0, 4'h0);
    // align ptr to 0, then full round robin 0,1,2,3,0,1
    add(STD, 4'b1000, 0, 0, 4'b1000, 12'h443, 1, 4'b1000, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b0001, 12'h1BA, 1, 4'b0001, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b0010, 12'h287, 1, 4'b0010, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b0100, 12'h323, 1, 4'b0100, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b1000, 12'h443, 1, 4'b1000, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b0001, 12'h1BA, 1, 4'b0001, 0, 2'd0, 4'h0);
    add(STD, 4'b1111, 0, 0, 4'b0010, 12'h287, 1, 4'b0010, 0, 2'd0, 4'h0);
    // illegal from 1, then illegal from 3 keeps first capture, then clear
    add({12'h443, 12'h323, 12'hFAB, 12'h1BA}, 4'b0010, 0, 0, 4'b0010, 12'h287, 0, 4'b0000, 1, 2'd1, 4'hF);
    add({12'hE00, 12'h323, 12'h287, 12'h1BA}, 4'b1000, 0, 0, 4'b1000, 12'h287, 0, 4'b0000, 1, 2'd1, 4'hF);
    add(STD, 4'b0000, 0, 1, 4'b0000, 12'h287, 0, 4'b0000, 0, 2'd1, 4'hF);
    // set error from 2, then clear collides with new illegal from 0
    add({12'h443, 12'hF55, 12'h287, 12'h1BA}, 4'b0100, 0, 0, 4'b0100, 12'h287, 0, 4'b0000, 1, 2'd2, 4'hF);
    add({12'h443, 12'h323, 12'h287, 12'hF11}, 4'b0001, 0, 1, 4'b0001, 12'h287, 0, 4'b0000, 1, 2'd0, 4'hF);
    add(STD, 4'b0000, 0, 1, 4'b0000, 12'h287, 0, 4'b0000, 0, 2'd0, 4'hF);
    // NOP is forwarded
    add({12'h443, 12'h323, 12'h05A, 12'h1BA}, 4'b0010, 0, 0, 4'b0010, 12'h05A, 1, 4'b0010, 0, 2'd0, 4'hF);
    // halt with ptr=2 for 4 cycles, then first grant to 2
    for (int k = 0; k < 4; k++)
      add(STD, 4'b1111, 1, 0, 4'b0000, 12'h05A, 0, 4'b0000, 0, 2'd0, 4'hF);
    add(STD, 4'b1111, 0, 0, 4'b0100, 12'h323, 1, 4'b0100, 0, 2'd0, 4'hF);
    // illegal during halt is not accepted
    add({12'hF00, 12'h323, 12'h287, 12'h1BA}, 4'b1000, 1, 0, 4'b0000, 12'h323, 0, 4'b0000, 0, 2'd0, 4'hF);
    add(STD, 4'b1000, 0, 0, 4'b1000, 12'h443, 1, 4'b1000, 0, 2'd0, 4'hF);

    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < nv; n++) apply(n);

    // reset mid-stream while requester 3's instruction is on the output
    @(negedge clock);
    req_valid = 4'b1010;
    chk("pre-reset inst_en", {15'h0, inst_en}, 16'h1);
    #1;
    reset = 1'b1;
    #1;
    e = '{-2, 12'h000, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0};
    check_outputs("async reset", e);
    chk("reset req_ready", {12'h0, req_ready}, 16'h0);
    @(posedge clock);
    #1;
    check_outputs("held reset", e);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-reset req_ready", {12'h0, req_ready}, 16'h2);
    sb.push_back('{-3, 12'h287, 1'b1, 4'b0010, 1'b0, 2'd0, 4'h0});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_outputs("post-reset grant", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
